uart_loopback_fifo: RTL and testbench

- Parametrised successor to the single-byte UART loopback.
- Configurable RX frame decoder (data bits, parity, stop bits, baud) feeds a synchronous FIFO, which feeds a matching TX frame encoder.
- Adds parity and framing error detection, start-bit glitch rejection, buffering with overflow reporting, and a TX enable for flow control.
- Sits between board UART pins and, later, a command parser.

---
 rtl/uart_loopback_fifo.sv | 369 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_loopback_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_fifo.sv
// ---------------------------------------------------------------------------
// uart_loopback_fifo
//
// Purpose:
//   UART receiver -> synchronous FIFO -> UART transmitter, all on one clock.
//   The frame format (data bits, parity, stop bits) and the baud divisor are
//   parameters, and RX and TX always use the same format. Received frames
//   with a bad stop bit or a bad parity bit are dropped and reported. Good
//   bytes that arrive while the FIFO is full are also dropped and reported.
//   tx_en stalls the transmitter between frames.
//
// Ports:
//   sys_clk        system clock
//   sys_rst        asynchronous, active-high reset
//   uart_rxd       serial input (asynchronous, synchronised internally)
//   uart_txd       serial output, idles high
//   tx_en          1 = TX may start a new frame; 0 = hold between frames
//   fifo_count     registered FIFO occupancy, 0..FIFO_DEPTH
//   rx_frame_err   one-cycle pulse: a stop bit was sampled low
//   rx_parity_err  one-cycle pulse: the parity bit did not match the data
//   fifo_overflow  one-cycle pulse: a good byte was dropped on a full FIFO
//
// Handshake: the RX side offers a byte to the FIFO with a one-cycle push
// strobe (valid only, no back-pressure: a full FIFO drops it). The TX side
// pops only when it is idle, tx_en is 1 and the FIFO is not empty. The popped
// word is read combinationally from the FIFO and latched on that same edge.
// ---------------------------------------------------------------------------
module uart_loopback_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst,
   input  logic                        uart_rxd,
   output logic                        uart_txd,
   input  logic                        tx_en,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        rx_frame_err,
   output logic                        rx_parity_err,
   output logic                        fifo_overflow
);

   localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
   localparam int CW       = $clog2(BAUD_CNT + 1);
   localparam int AW       = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] CNT_LAST    = CW'(BAUD_CNT - 1);
   localparam logic [CW-1:0] CNT_PRELAST = CW'(BAUD_CNT - 2);
   localparam logic [CW-1:0] CNT_HALF    = CW'(BAUD_CNT / 2);
   localparam logic [2:0]    BIT_LAST    = 3'(DATA_BITS - 1);
   localparam logic          PAR_ODD     = (PARITY == 1);
   localparam logic          HAS_PARITY  = (PARITY != 0);
   localparam logic          TWO_STOP    = (STOP_BITS == 2);

   // ------------------------------------------------------------------------
   // RX input synchroniser and falling-edge detector (idle level is 1)
   // ------------------------------------------------------------------------
   logic rx_meta;
   logic rx_sync;
   logic rx_prev;
   logic rx_fall;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rxd;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign rx_fall = rx_prev & ~rx_sync;

   // ------------------------------------------------------------------------
   // RX frame decoder
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   rx_state_t            rx_state;
   rx_state_t            rx_next;
   logic [CW-1:0]        rx_cnt;
   logic [2:0]           rx_bit;
   logic                 rx_stop_idx;
   logic                 rx_stop_bad;
   logic                 rx_par_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_bit_tick;
   logic                 rx_sample;
   logic                 rx_par_bad;
   logic                 rx_done_good;
   logic                 rx_done_ferr;
   logic                 rx_done_perr;
   logic                 rx_push;
   logic [DATA_BITS-1:0] rx_push_data;

   assign rx_bit_tick = (rx_cnt == CNT_LAST);
   assign rx_sample   = rx_bit_tick &&
                        ((rx_state == RX_DATA) || (rx_state == RX_PARITY) ||
                         (rx_state == RX_STOP));
   assign rx_par_bad  = HAS_PARITY && (rx_par_bit != ((^rx_shift) ^ PAR_ODD));

   always_comb begin
      rx_next      = rx_state;
      rx_done_good = 1'b0;
      rx_done_ferr = 1'b0;
      rx_done_perr = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_fall) rx_next = RX_START;
         end
         RX_START: begin
            // A line that is high again at mid start bit was only a glitch.
            if (rx_cnt == CNT_HALF) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (rx_bit_tick && (rx_bit == BIT_LAST))
               rx_next = HAS_PARITY ? RX_PARITY : RX_STOP;
         end
         RX_PARITY: begin
            if (rx_bit_tick) rx_next = RX_STOP;
         end
         RX_STOP: begin
            if (rx_bit_tick && (!TWO_STOP || rx_stop_idx)) begin
               // Frame error wins over parity error, so at most one pulses.
               if (rx_stop_bad || !rx_sync) begin
                  rx_done_ferr = 1'b1;
                  rx_next      = RX_WAIT_HIGH;
               end else if (rx_par_bad) begin
                  rx_done_perr = 1'b1;
                  rx_next      = RX_IDLE;
               end else begin
                  rx_done_good = 1'b1;
                  rx_next      = RX_IDLE;
               end
            end
         end
         RX_WAIT_HIGH: begin
            // A held-low line (break) must go high before a new start counts.
            if (rx_sync) rx_next = RX_IDLE;
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rx_state      <= RX_IDLE;
         rx_cnt        <= '0;
         rx_bit        <= '0;
         rx_stop_idx   <= 1'b0;
         rx_stop_bad   <= 1'b0;
         rx_par_bit    <= 1'b0;
         rx_shift      <= '0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_push       <= 1'b0;
         rx_push_data  <= '0;
      end else begin
         rx_state      <= rx_next;
         rx_frame_err  <= rx_done_ferr;
         rx_parity_err <= rx_done_perr;
         rx_push       <= rx_done_good;
         if (rx_done_good) rx_push_data <= rx_shift;

         // The baud counter restarts on every state change and every sample.
         if ((rx_state == RX_IDLE) || (rx_state == RX_WAIT_HIGH) ||
             (rx_next != rx_state) || rx_sample)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;

         if ((rx_state == RX_IDLE) && rx_fall) begin
            rx_bit      <= '0;
            rx_stop_idx <= 1'b0;
            rx_stop_bad <= 1'b0;
         end

         if (rx_sample) begin
            case (rx_state)
               RX_DATA: begin
                  rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                  rx_bit   <= (rx_bit == BIT_LAST) ? 3'd0 : rx_bit + 3'd1;
               end
               RX_PARITY: rx_par_bit <= rx_sync;
               RX_STOP: begin
                  rx_stop_idx <= 1'b1;
                  rx_stop_bad <= rx_stop_bad | ~rx_sync;
               end
               default: ;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Synchronous FIFO. Pointers carry one extra wrap bit: equal pointers mean
   // empty, pointers differing only in the wrap bit mean full.
   // ------------------------------------------------------------------------
   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 fifo_wr;
   logic                 tx_pop;
   logic [DATA_BITS-1:0] fifo_rdata;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A same-cycle pop frees the slot, so a push into a full FIFO is kept.
   assign fifo_wr    = rx_push && (!fifo_full || tx_pop);
   assign fifo_rdata = fifo_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge sys_clk) begin
      if (fifo_wr) fifo_mem[wr_ptr[AW-1:0]] <= rx_push_data;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         fifo_overflow <= 1'b0;
      end else begin
         fifo_overflow <= rx_push && fifo_full && !tx_pop;
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (fifo_wr && !tx_pop)
            fifo_count <= fifo_count + 1'b1;
         else if (!fifo_wr && tx_pop)
            fifo_count <= fifo_count - 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // TX frame encoder
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   tx_state_t            tx_state;
   tx_state_t            tx_next;
   logic [CW-1:0]        tx_cnt;
   logic [2:0]           tx_bit;
   logic                 tx_stop_idx;
   logic                 tx_par;
   logic [DATA_BITS-1:0] tx_shift;
   logic                 tx_bit_tick;

   assign tx_bit_tick = (tx_cnt == CNT_LAST);

   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (tx_en && !fifo_empty) begin
               tx_pop  = 1'b1;
               tx_next = TX_START;
            end
         end
         TX_START: begin
            if (tx_bit_tick) tx_next = TX_DATA;
         end
         TX_DATA: begin
            if (tx_bit_tick && (tx_bit == BIT_LAST))
               tx_next = HAS_PARITY ? TX_PARITY : TX_STOP;
         end
         TX_PARITY: begin
            if (tx_bit_tick) tx_next = TX_STOP;
         end
         TX_STOP: begin
            // Leave one cycle early: the IDLE cycle is the last cycle of the
            // final stop bit, so back-to-back frames keep exact bit widths.
            if ((!TWO_STOP || tx_stop_idx) && (tx_cnt == CNT_PRELAST))
               tx_next = TX_IDLE;
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         tx_state    <= TX_IDLE;
         tx_cnt      <= '0;
         tx_bit      <= '0;
         tx_stop_idx <= 1'b0;
         tx_par      <= 1'b0;
         tx_shift    <= '0;
         uart_txd    <= 1'b1;
      end else begin
         tx_state <= tx_next;
         case (tx_state)
            TX_IDLE: begin
               uart_txd <= 1'b1;
               if (tx_pop) begin
                  tx_shift    <= fifo_rdata;
                  tx_par      <= (^fifo_rdata) ^ PAR_ODD;
                  tx_cnt      <= '0;
                  tx_bit      <= '0;
                  tx_stop_idx <= 1'b0;
                  uart_txd    <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_bit_tick) begin
                  tx_cnt   <= '0;
                  uart_txd <= tx_shift[0];
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_bit_tick) begin
                  tx_cnt <= '0;
                  if (tx_bit == BIT_LAST) begin
                     uart_txd <= HAS_PARITY ? tx_par : 1'b1;
                  end else begin
                     tx_shift <= tx_shift >> 1;
                     uart_txd <= tx_shift[1];
                     tx_bit   <= tx_bit + 3'd1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_PARITY: begin
               if (tx_bit_tick) begin
                  tx_cnt   <= '0;
                  uart_txd <= 1'b1;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               uart_txd <= 1'b1;
               if (tx_bit_tick) begin
                  tx_cnt      <= '0;
                  tx_stop_idx <= 1'b1;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: uart_txd <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_loopback_fifo
//
// Three instances share clock, reset and tx_en: dut0 with default parameters
// (434 cycles per bit), dut1 8N1 with a 16-cycle bit, dut2 7E1 with a 16-cycle
// bit. Only the instance selected by `sel` is stimulated; its outputs are
// muxed onto the *_m signals watched by the TX monitor and pulse watcher.
// Expected bytes are queued when a good frame is driven and popped when the
// monitor decodes a complete frame on uart_txd.
// ---------------------------------------------------------------------------
module tb_uart_loopback_fifo;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic       rst;
   logic       tx_en;
   logic       rxd0, rxd1, rxd2;
   logic       txd0, txd1, txd2;
   logic [4:0] cnt0, cnt1, cnt2;
   logic       fe0, fe1, fe2;
   logic       pe0, pe1, pe2;
   logic       ov0, ov1, ov2;

   uart_loopback_fifo dut0 (
      .sys_clk(clk), .sys_rst(rst), .uart_rxd(rxd0), .uart_txd(txd0),
      .tx_en(tx_en), .fifo_count(cnt0), .rx_frame_err(fe0),
      .rx_parity_err(pe0), .fifo_overflow(ov0)
   );

   uart_loopback_fifo #(.CLK_FREQ(16000000), .BAUD_RATE(1000000)) dut1 (
      .sys_clk(clk), .sys_rst(rst), .uart_rxd(rxd1), .uart_txd(txd1),
      .tx_en(tx_en), .fifo_count(cnt1), .rx_frame_err(fe1),
      .rx_parity_err(pe1), .fifo_overflow(ov1)
   );

   uart_loopback_fifo #(.CLK_FREQ(16000000), .BAUD_RATE(1000000),
                        .DATA_BITS(7), .PARITY(2)) dut2 (
      .sys_clk(clk), .sys_rst(rst), .uart_rxd(rxd2), .uart_txd(txd2),
      .tx_en(tx_en), .fifo_count(cnt2), .rx_frame_err(fe2),
      .rx_parity_err(pe2), .fifo_overflow(ov2)
   );

   int sel;
   logic       txd_m, fe_m, pe_m, ov_m;
   logic [4:0] cnt_m;
   assign txd_m = (sel == 0) ? txd0 : (sel == 1) ? txd1 : txd2;
   assign cnt_m = (sel == 0) ? cnt0 : (sel == 1) ? cnt1 : cnt2;
   assign fe_m  = (sel == 0) ? fe0  : (sel == 1) ? fe1  : fe2;
   assign pe_m  = (sel == 0) ? pe0  : (sel == 1) ? pe1  : pe2;
   assign ov_m  = (sel == 0) ? ov0  : (sel == 1) ? ov1  : ov2;

   int tests;
   int fails;
   logic [7:0] exp_q[$];

   // frame format of the selected instance
   int cur_b, cur_nd, cur_par, cur_sb;

   int cyc;
   int frames_done, tx_starts, start_cyc, prev_start;
   bit have_prev, b2b_chk;
   bit clr;
   int fe_n, pe_n, ov_n, peak, first1, ovf_byte, cur_byte;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic tick_counter();
      forever begin
         @(posedge clk);
         cyc++;
      end
   endtask

   // Counts pulses and tracks FIFO occupancy on the selected instance.
   task automatic watcher();
      forever begin
         @(negedge clk);
         if (clr) begin
            fe_n = 0; pe_n = 0; ov_n = 0; peak = 0; first1 = -1; ovf_byte = -1;
         end else if (!rst) begin
            if (fe_m) fe_n++;
            if (pe_m) pe_n++;
            if (ov_m) begin
               ov_n++;
               ovf_byte = cur_byte;
            end
            if (int'(cnt_m) > peak) peak = int'(cnt_m);
            if ((cnt_m == 5'd1) && (first1 < 0)) first1 = cyc;
         end
      end
   endtask

   // Decodes frames on uart_txd of the selected instance, checking every
   // cycle of every bit, then compares the data against the scoreboard.
   task automatic tx_monitor();
      logic [15:0] vals;
      logic [7:0]  d;
      logic [7:0]  ev;
      int nbits, b, nd, par, sb;
      bit stable, aborted;
      forever begin
         @(negedge clk);
         if (!rst && (txd_m === 1'b0)) begin
            b = cur_b; nd = cur_nd; par = cur_par; sb = cur_sb;
            nbits = 1 + nd + ((par != 0) ? 1 : 0) + sb;
            start_cyc = cyc;
            tx_starts++;
            if (b2b_chk && have_prev) chk("tx_b2b_period", start_cyc - prev_start, nbits * b);
            prev_start = start_cyc;
            have_prev  = 1'b1;
            vals = '0; stable = 1'b1; aborted = 1'b0;
            for (int j = 0; j < nbits * b; j++) begin
               if (j > 0) @(negedge clk);
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
               if ((j % b) == 0) vals[j / b] = txd_m;
               else if (txd_m !== vals[j / b]) stable = 1'b0;
            end
            if (!aborted) begin
               frames_done++;
               d = '0;
               for (int i = 0; i < nd; i++) d[i] = vals[1 + i];
               chk("tx_bit_stable", int'(stable), 1);
               chk("tx_start_bit", int'(vals[0]), 0);
               if (par != 0)
                  chk("tx_parity_bit", int'(vals[nd + 1]), int'((^d) ^ (par == 1)));
               for (int s = 0; s < sb; s++)
                  chk("tx_stop_bit", int'(vals[nbits - 1 - s]), 1);
               chk("tx_frame_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  ev = exp_q.pop_front();
                  chk("tx_data", int'(d), int'(ev));
               end
            end
         end
      end
   endtask

   task automatic clear();
      clr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic drive_rx(input logic v, input int n);
      case (sel)
         0:       rxd0 = v;
         1:       rxd1 = v;
         default: rxd2 = v;
      endcase
      repeat (n) @(posedge clk);
   endtask

   // pbit < 0 means no parity bit on the line
   task automatic send_frame(input logic [7:0] d, input int nd, input int pbit,
                             input logic stop_v, input int nstop);
      drive_rx(1'b0, cur_b);
      for (int i = 0; i < nd; i++) drive_rx(d[i], cur_b);
      if (pbit >= 0) drive_rx(pbit[0], cur_b);
      for (int s = 0; s < nstop; s++) drive_rx(stop_v, cur_b);
   endtask

   task automatic wait_frames(input int target, input int budget);
      int k;
      k = 0;
      while ((frames_done < target) && (k < budget)) begin
         @(posedge clk);
         k++;
      end
      chk("tx_frames_done", frames_done, target);
   endtask

   initial begin
      int base;
      int s0;
      int k;
      tests = 0; fails = 0;
      rst = 1'b1; tx_en = 1'b1;
      rxd0 = 1'b1; rxd1 = 1'b1; rxd2 = 1'b1;
      sel = 0; cur_b = 434; cur_nd = 8; cur_par = 0; cur_sb = 1;
      cyc = 0; frames_done = 0; tx_starts = 0; start_cyc = 0; prev_start = 0;
      have_prev = 1'b0; b2b_chk = 1'b0; clr = 1'b0;
      fe_n = 0; pe_n = 0; ov_n = 0; peak = 0; first1 = -1; ovf_byte = -1; cur_byte = 0;
      fork
         tick_counter();
         watcher();
         tx_monitor();
      join_none

      // ---- reset state
      idle(5);
      #1;
      chk("rst_txd0", int'(txd0), 1);
      chk("rst_txd1", int'(txd1), 1);
      chk("rst_txd2", int'(txd2), 1);
      chk("rst_count0", int'(cnt0), 0);
      chk("rst_pulses0", int'({fe0, pe0, ov0}), 0);
      chk("rst_pulses2", int'({fe2, pe2, ov2}), 0);
      @(negedge clk);
      rst = 1'b0;
      idle(10);

      // ---- defaults 8N1, 434 cycles per bit: 0x55 loops back
      clear();
      base = frames_done;
      exp_q.push_back(8'h55);
      send_frame(8'h55, 8, -1, 1'b1, 1);
      wait_frames(base + 1, 30 * 434);
      idle(10);
      chk("def_fifo_peak", peak, 1);
      chk("def_write_to_txd_latency", start_cyc - first1, 1);
      chk("def_frame_err", fe_n, 0);
      chk("def_parity_err", pe_n, 0);
      chk("def_overflow", ov_n, 0);
      chk("def_count_end", int'(cnt_m), 0);

      // ---- fast 8N1 instance
      sel = 1; cur_b = 16; cur_nd = 8; cur_par = 0; cur_sb = 1;
      idle(20);

      // glitch: 5 cycles low
      clear();
      s0 = tx_starts;
      drive_rx(1'b0, 5);
      drive_rx(1'b1, 80);
      chk("glitch_fifo_peak", peak, 0);
      chk("glitch_tx_starts", tx_starts, s0);
      chk("glitch_pulses", fe_n + pe_n + ov_n, 0);
      chk("glitch_txd", int'(txd_m), 1);

      // framing error: 0xA3 with stop held low for two bit times
      clear();
      send_frame(8'hA3, 8, -1, 1'b0, 2);
      drive_rx(1'b1, 3 * 16);
      chk("ferr_pulses", fe_n, 1);
      chk("ferr_no_parity_err", pe_n, 0);
      chk("ferr_fifo_peak", peak, 0);
      chk("ferr_tx_starts", tx_starts, s0);
      base = frames_done;
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 8, -1, 1'b1, 1);
      wait_frames(base + 1, 400);
      chk("ferr_after_pulses", fe_n, 1);

      // overflow with tx_en low, then back-to-back drain
      idle(20);
      tx_en = 1'b0;
      clear();
      s0 = tx_starts;
      for (int i = 0; i < 17; i++) begin
         cur_byte = i;
         if (i < 16) exp_q.push_back(8'(i));
         send_frame(8'(i), 8, -1, 1'b1, 1);
      end
      idle(20);
      chk("ovf_count_full", int'(cnt_m), 16);
      chk("ovf_pulses", ov_n, 1);
      chk("ovf_on_byte", ovf_byte, 16);
      chk("ovf_held_tx", tx_starts, s0);
      chk("ovf_frame_err", fe_n, 0);
      base = frames_done;
      have_prev = 1'b0;
      b2b_chk = 1'b1;
      tx_en = 1'b1;
      wait_frames(base + 16, 16 * 10 * 16 + 200);
      b2b_chk = 1'b0;
      idle(5);
      chk("ovf_count_drained", int'(cnt_m), 0);

      // ---- 7E1 instance
      sel = 2; cur_b = 16; cur_nd = 7; cur_par = 2; cur_sb = 1;
      idle(20);
      clear();
      base = frames_done;
      exp_q.push_back(8'h55);
      send_frame(8'h55, 7, 0, 1'b1, 1);
      wait_frames(base + 1, 400);
      chk("par_good_no_err", pe_n, 0);
      idle(20);
      clear();
      s0 = tx_starts;
      send_frame(8'h55, 7, 1, 1'b1, 1);
      idle(60);
      chk("par_bad_pulse", pe_n, 1);
      chk("par_bad_no_frame_err", fe_n, 0);
      chk("par_bad_no_echo", tx_starts, s0);
      chk("par_bad_fifo_peak", peak, 0);

      // ---- reset mid-frame on the fast 8N1 instance
      sel = 1; cur_b = 16; cur_nd = 8; cur_par = 0; cur_sb = 1;
      idle(20);
      tx_en = 1'b0;
      send_frame(8'hC6, 8, -1, 1'b1, 1);
      send_frame(8'h5A, 8, -1, 1'b1, 1);
      idle(20);
      chk("rst_pre_count", int'(cnt_m), 2);
      s0 = tx_starts;
      tx_en = 1'b1;
      k = 0;
      while ((tx_starts == s0) && (k < 100)) begin
         @(posedge clk);
         k++;
      end
      chk("rst_tx_started", tx_starts, s0 + 1);
      k = 0;
      while ((cyc < start_cyc + 4 * 16 + 8) && (k < 500)) begin
         @(negedge clk);
         k++;
      end
      rst = 1'b1;
      #1;
      chk("rst_mid_txd", int'(txd_m), 1);
      chk("rst_mid_count", int'(cnt_m), 0);
      idle(3);
      @(negedge clk);
      rst = 1'b0;
      idle(200);
      chk("rst_fifo_discarded", tx_starts, s0 + 1);
      chk("rst_no_pending_exp", exp_q.size(), 0);
      base = frames_done;
      exp_q.push_back(8'h81);
      send_frame(8'h81, 8, -1, 1'b1, 1);
      wait_frames(base + 1, 400);
      idle(20);
      chk("end_exp_q_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
